// File: rtl/ring_checker.sv
// Receive-side monitor for a one-hot ring code stream: decodes the set bit to an index,
// checks one-hot validity and single-step left rotation, tracks lock and counts errors.
module ring_checker #(
  parameter int WIDTH      = 8,
  parameter int IDX_W      = 3,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] code,
  input  logic             code_valid,
  input  logic             err_clr,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             code_err,
  output logic             step_err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] ref_code, ref_nxt, ref_rot;
  logic [3:0]       good_cnt, good_nxt;
  logic [3:0]       bad_cnt, bad_nxt;
  logic             onehot;
  logic [IDX_W-1:0] code_idx;
  logic             code_err_nxt, step_err_nxt, wrap_nxt;

  assign ref_rot = {ref_code[WIDTH-2:0], ref_code[WIDTH-1]};
  assign onehot  = (code != '0) && ((code & (code - WIDTH'(1))) == '0);

  always_comb begin
    code_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (code[i]) code_idx = IDX_W'(i);
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt    = state;
    ref_nxt      = ref_code;
    good_nxt     = good_cnt;
    bad_nxt      = bad_cnt;
    code_err_nxt = 1'b0;
    step_err_nxt = 1'b0;
    wrap_nxt     = 1'b0;
    if (code_valid) begin
      unique case (state)
        HUNT: begin
          if (onehot) begin
            ref_nxt   = code;
            good_nxt  = '0;
            state_nxt = ACQ;
          end else begin
            code_err_nxt = 1'b1;
          end
        end
        ACQ: begin
          if (!onehot) begin
            code_err_nxt = 1'b1;
            state_nxt    = HUNT;
          end else if (code == ref_rot) begin
            ref_nxt  = code;
            good_nxt = good_cnt + 4'd1;
            if (good_nxt == LOCK_N) begin
              state_nxt = LOCKED;
              bad_nxt   = '0;
            end
          end else begin
            step_err_nxt = 1'b1;
            ref_nxt      = code;
            good_nxt     = '0;
          end
        end
        LOCKED: begin
          if (onehot && code == ref_rot) begin
            ref_nxt  = code;
            bad_nxt  = '0;
            wrap_nxt = code[0];
          end else begin
            if (onehot) begin
              step_err_nxt = 1'b1;
              ref_nxt      = code;
            end else begin
              // Flywheel: keep the reference advancing through a corrupted sample.
              code_err_nxt = 1'b1;
              ref_nxt      = ref_rot;
            end
            bad_nxt = bad_cnt + 4'd1;
            if (bad_nxt == UNLOCK_N) state_nxt = HUNT;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state     <= HUNT;
      ref_code  <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      idx       <= '0;
      idx_valid <= 1'b0;
      locked    <= 1'b0;
      code_err  <= 1'b0;
      step_err  <= 1'b0;
      wrap      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      ref_code  <= ref_nxt;
      good_cnt  <= good_nxt;
      bad_cnt   <= bad_nxt;
      idx_valid <= code_valid && onehot;
      if (code_valid && onehot) idx <= code_idx;
      locked    <= (state_nxt == LOCKED);
      code_err  <= code_err_nxt;
      step_err  <= step_err_nxt;
      wrap      <= wrap_nxt;
      if (err_clr) begin
        err_cnt <= '0;
      end else if ((code_err_nxt || step_err_nxt) && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

endmodule
